// File: rtl/weight_compress.sv
// weight_compress: streaming sparse-weight encoder.
// Accepts one dense KERNEL_SIZE-element kernel (row-major, one element per
// cycle over in_valid/in_ready). It writes the kept elements serially on the
// value port, then writes the nonzero bitmap on the flag port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mode              0 = drop zeros, 1 = bypass (keep every element)
//   start             pulse that begins a new kernel (aborts one in flight)
//   in_valid/in_data  dense element stream
//   in_ready          high while collecting a kernel
//   wr_req_wei/wr_data_wei            value write, one cycle after accept
//   wr_req_wei_flag/wr_data_wei_flag  bitmap write, one cycle per kernel
//   row_val_num       per-row kept counts, row r at [r*ROW_CNT_WIDTH +: ROW_CNT_WIDTH]
//   nnz_count         total values written for the current kernel
//   busy              high while collecting or emitting
//   done              pulse coincident with the bitmap write
module weight_compress #(
  parameter int DATA_WIDTH    = 8,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_SIZE   = 9,
  parameter int ROW_CNT_WIDTH = 2,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  mode,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic signed [DATA_WIDTH-1:0]          in_data,
  output logic                                  in_ready,
  output logic                                  wr_req_wei,
  output logic signed [DATA_WIDTH-1:0]          wr_data_wei,
  output logic                                  wr_req_wei_flag,
  output logic [KERNEL_SIZE-1:0]                wr_data_wei_flag,
  output logic [ROW_CNT_WIDTH*KERNEL_WIDTH-1:0] row_val_num,
  output logic [CNT_WIDTH-1:0]                  nnz_count,
  output logic                                  busy,
  output logic                                  done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t                                state_q, state_d;
  logic [CNT_WIDTH-1:0]                  idx_q, idx_d;
  logic [KERNEL_SIZE-1:0]                bitmap_q, bitmap_d;
  logic [ROW_CNT_WIDTH*KERNEL_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_WIDTH-1:0]                  nnz_q, nnz_d;
  logic                                  wr_req_q, wr_req_d;
  logic signed [DATA_WIDTH-1:0]          wr_data_q, wr_data_d;
  logic                                  flag_req_q, flag_req_d;
  logic                                  done_q, done_d;
  logic                                  keep;
  logic                                  clear;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bitmap_d   = bitmap_q;
    row_cnt_d  = row_cnt_q;
    nnz_d      = nnz_q;
    wr_req_d   = 1'b0;
    wr_data_d  = '0;
    flag_req_d = 1'b0;
    done_d     = 1'b0;
    clear      = 1'b0;
    keep       = (in_data != '0) | mode;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          clear   = 1'b1;
        end
      end
      S_COLLECT: begin
        // A start here aborts the kernel; an element offered in the same
        // cycle is dropped because the restart takes priority.
        if (start) begin
          clear = 1'b1;
        end else if (in_valid) begin
          wr_req_d  = keep;
          wr_data_d = keep ? in_data : '0;
          nnz_d     = nnz_q + CNT_WIDTH'(keep);
          idx_d     = idx_q + CNT_WIDTH'(1);
          // Constant-bounded scan keeps bitmap and row-count indexing static.
          for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (idx_q == CNT_WIDTH'(i)) begin
              bitmap_d[i] = keep;
              row_cnt_d[(i / KERNEL_WIDTH) * ROW_CNT_WIDTH +: ROW_CNT_WIDTH] =
                row_cnt_q[(i / KERNEL_WIDTH) * ROW_CNT_WIDTH +: ROW_CNT_WIDTH]
                + ROW_CNT_WIDTH'(keep);
            end
          end
          if (idx_q == CNT_WIDTH'(KERNEL_SIZE - 1)) begin
            state_d    = S_EMIT;
            flag_req_d = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (start) begin
          state_d = S_COLLECT;
          clear   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      idx_d     = '0;
      bitmap_d  = '0;
      row_cnt_d = '0;
      nnz_d     = '0;
    end
  end

  // Stage boundary: accepted element -> registered writes and kernel state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      bitmap_q   <= '0;
      row_cnt_q  <= '0;
      nnz_q      <= '0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      flag_req_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bitmap_q   <= bitmap_d;
      row_cnt_q  <= row_cnt_d;
      nnz_q      <= nnz_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      flag_req_q <= flag_req_d;
      done_q     <= done_d;
    end
  end

  assign in_ready         = (state_q == S_COLLECT);
  assign busy             = (state_q != S_IDLE);
  assign wr_req_wei       = wr_req_q;
  assign wr_data_wei      = wr_data_q;
  assign wr_req_wei_flag  = flag_req_q;
  assign wr_data_wei_flag = bitmap_q;
  assign row_val_num      = row_cnt_q;
  assign nnz_count        = nnz_q;
  assign done             = done_q;

endmodule

// File: tb/tb_weight_compress.sv
module tb_weight_compress;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_req_wei;
  logic [7:0] wr_data_wei;
  logic       wr_req_wei_flag;
  logic [8:0] wr_data_wei_flag;
  logic [5:0] row_val_num;
  logic [3:0] nnz_count;
  logic       busy;
  logic       done;

  weight_compress dut (
    .clk              (clk),
    .reset            (reset),
    .mode             (mode),
    .start            (start),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .wr_req_wei       (wr_req_wei),
    .wr_data_wei      (wr_data_wei),
    .wr_req_wei_flag  (wr_req_wei_flag),
    .wr_data_wei_flag (wr_data_wei_flag),
    .row_val_num      (row_val_num),
    .nnz_count        (nnz_count),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] kern_t [9];

  typedef struct {
    logic [7:0]  d;
    int unsigned cyc;
  } val_exp_t;

  typedef struct {
    logic [8:0]  flag;
    logic [5:0]  row;
    logic [3:0]  nnz;
    int unsigned cyc;
  } flag_exp_t;

  val_exp_t    vq[$];
  flag_exp_t   fq[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write.
  always @(negedge clk) begin
    if (wr_req_wei) begin
      if (vq.size() == 0) begin
        chk("unexpected_value_write", {24'd0, wr_data_wei}, 32'hFFFF_FFFF);
      end else begin
        val_exp_t e;
        e = vq.pop_front();
        chk("value_data", {24'd0, wr_data_wei}, {24'd0, e.d});
        chk("value_cycle", cyc, e.cyc);
      end
    end
    if (wr_req_wei_flag) begin
      if (fq.size() == 0) begin
        chk("unexpected_flag_write", {23'd0, wr_data_wei_flag}, 32'hFFFF_FFFF);
      end else begin
        flag_exp_t f;
        f = fq.pop_front();
        chk("flag_bitmap", {23'd0, wr_data_wei_flag}, {23'd0, f.flag});
        chk("flag_row_val_num", {26'd0, row_val_num}, {26'd0, f.row});
        chk("flag_nnz_count", {28'd0, nnz_count}, {28'd0, f.nnz});
        chk("flag_done", {31'd0, done}, 32'd1);
        chk("flag_cycle", cyc, f.cyc);
      end
    end else if (done) begin
      chk("done_without_flag", {31'd0, done}, 32'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_wr_req_wei"}, {31'd0, wr_req_wei}, 32'd0);
    chk({tag, "_wr_data_wei"}, {24'd0, wr_data_wei}, 32'd0);
    chk({tag, "_wr_req_wei_flag"}, {31'd0, wr_req_wei_flag}, 32'd0);
    chk({tag, "_wr_data_wei_flag"}, {23'd0, wr_data_wei_flag}, 32'd0);
    chk({tag, "_row_val_num"}, {26'd0, row_val_num}, 32'd0);
    chk({tag, "_nnz_count"}, {28'd0, nnz_count}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_values_pending"}, vq.size(), 32'd0);
    chk({tag, "_flags_pending"}, fq.size(), 32'd0);
  endtask

  // Start pulse (with a decoy element that must never be accepted), then the
  // nine elements. Returns in the EMIT cycle unless go_idle is set.
  task automatic run_kernel(input logic m, input kern_t d, input bit gaps,
                            input logic [8:0] eflag, input logic [5:0] erow,
                            input logic [3:0] ennz, input bit go_idle);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    mode     = m;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("in_ready_collect", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        in_data  = 8'hAA;
        tick();
        chk("in_ready_gap", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b1;
      in_data  = d[i];
      if (m || d[i] != 8'd0) vq.push_back('{d: d[i], cyc: cyc + 1});
      if (i == 8) fq.push_back('{flag: eflag, row: erow, nnz: ennz, cyc: cyc + 1});
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
    chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
    chk("busy_emit", {31'd0, busy}, 32'd1);
    if (go_idle) begin
      tick();
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("hold_flag", {23'd0, wr_data_wei_flag}, {23'd0, eflag});
      chk("hold_row", {26'd0, row_val_num}, {26'd0, erow});
      chk("hold_nnz", {28'd0, nnz_count}, {28'd0, ennz});
      tick();
      check_drained("kernel");
    end
  endtask

  // Start and feed four elements [1,2,0,4] in mode 0.
  task automatic partial4;
    start    = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 2) ? 8'd0 : 8'(i + 1 + (i == 3 ? 0 : 0));
      if (i == 3) in_data = 8'd4;
      if (in_data != 8'd0) vq.push_back('{d: in_data, cyc: cyc + 1});
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  kern_t ka, kz, kb, kc;

  initial begin
    ka = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'hFD, 8'd7, 8'd0, 8'd1};
    kz = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    kb = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
    kc = '{8'd3, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    reset    = 1'b1;
    mode     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    tick();
    tick();
    check_zero("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_zero("idle");
    end

    // Sparse kernel, no gaps, then with gaps.
    run_kernel(1'b0, ka, 1'b0, 9'h162, 6'h25, 4'd4, 1'b1);
    run_kernel(1'b0, ka, 1'b1, 9'h162, 6'h25, 4'd4, 1'b1);

    // All-zero kernel in bypass and in compress mode.
    run_kernel(1'b1, kz, 1'b0, 9'h1FF, 6'h3F, 4'd9, 1'b1);
    run_kernel(1'b0, kz, 1'b0, 9'h000, 6'h00, 4'd0, 1'b1);

    // Back-to-back: start lands in the first kernel's EMIT cycle.
    run_kernel(1'b0, ka, 1'b0, 9'h162, 6'h25, 4'd4, 1'b0);
    run_kernel(1'b0, kb, 1'b0, 9'h101, 6'h11, 4'd2, 1'b1);

    // Abort after four elements; restart start carries a discarded element.
    partial4();
    run_kernel(1'b0, kc, 1'b0, 9'h007, 6'h03, 4'd3, 1'b1);

    // Reset mid-kernel.
    partial4();
    reset = 1'b1;
    tick();
    check_zero("mid_reset");
    reset = 1'b0;
    tick();
    tick();
    check_zero("after_reset");
    check_drained("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
